psg_stereo_dac: RTL

PSG_STEREO_DAC -- requirements
Module: psg_stereo_dac

---
 rtl/psg_stereo_dac.sv | 104 ++++++++++
 1 files changed

// File: rtl/psg_stereo_dac.sv
// PSG stereo mixer: samples three channel levels on CE, mixes them per stereo mode
// into 10-bit PCM one edge later, and drives first-order sigma-delta bitstreams.
module psg_stereo_dac (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  input  logic [7:0] CH_A,
  input  logic [7:0] CH_B,
  input  logic [7:0] CH_C,
  input  logic [1:0] MODE_SEL,
  output logic [9:0] AUDIO_L,
  output logic [9:0] AUDIO_R,
  output logic       VALID,
  output logic       DAC_L,
  output logic       DAC_R
);

  localparam int unsigned CH_W  = 8;
  localparam int unsigned PCM_W = 10;
  localparam int unsigned ACC_W = PCM_W + 1;

  localparam logic [1:0] MODE_MONO = 2'b00;
  localparam logic [1:0] MODE_ABC  = 2'b01;
  localparam logic [1:0] MODE_ACB  = 2'b10;

  logic [CH_W-1:0]  smp_a, smp_b, smp_c;
  logic [1:0]       smp_mode;
  logic             smp_valid;
  logic [PCM_W-1:0] mix_l_c, mix_r_c;
  logic [ACC_W-1:0] acc_l, acc_r;

  // Stage 1: sample registers; smp_valid marks a freshly latched sample
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      smp_a     <= '0;
      smp_b     <= '0;
      smp_c     <= '0;
      smp_mode  <= MODE_MONO;
      smp_valid <= 1'b0;
    end else begin
      smp_valid <= CE;
      if (CE) begin
        smp_a    <= CH_A;
        smp_b    <= CH_B;
        smp_c    <= CH_C;
        smp_mode <= MODE_SEL;
      end
    end
  end

  // Mixer: doubled channel sits on its own side, shared channel goes to both
  always_comb begin
    mix_l_c = '0;
    mix_r_c = '0;
    case (smp_mode)
      MODE_MONO: begin
        mix_l_c = PCM_W'(smp_a) + PCM_W'(smp_b) + PCM_W'(smp_c);
        mix_r_c = mix_l_c;
      end
      MODE_ABC: begin
        mix_l_c = PCM_W'({smp_a, 1'b0}) + PCM_W'(smp_b);
        mix_r_c = PCM_W'({smp_c, 1'b0}) + PCM_W'(smp_b);
      end
      MODE_ACB: begin
        mix_l_c = PCM_W'({smp_a, 1'b0}) + PCM_W'(smp_c);
        mix_r_c = PCM_W'({smp_b, 1'b0}) + PCM_W'(smp_c);
      end
      default: begin
        mix_l_c = '0;
        mix_r_c = '0;
      end
    endcase
  end

  // Stage 2: PCM outputs update only for a freshly latched sample
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      AUDIO_L <= '0;
      AUDIO_R <= '0;
      VALID   <= 1'b0;
    end else begin
      VALID <= smp_valid;
      if (smp_valid) begin
        AUDIO_L <= mix_l_c;
        AUDIO_R <= mix_r_c;
      end
    end
  end

  // Sigma-delta: carry out of the 10-bit residue is the output bit, every cycle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_l <= '0;
      acc_r <= '0;
    end else begin
      acc_l <= {1'b0, acc_l[PCM_W-1:0]} + {1'b0, AUDIO_L};
      acc_r <= {1'b0, acc_r[PCM_W-1:0]} + {1'b0, AUDIO_R};
    end
  end

  assign DAC_L = acc_l[PCM_W];
  assign DAC_R = acc_r[PCM_W];

endmodule
